// File: rtl/biriscv_div_arbiter_if.sv
// rtl/biriscv_div_arbiter_if.sv - request, divider and writeback signals of the divider arbiter
interface biriscv_div_arbiter_if;
  logic        flush_i;

  logic        p0_valid_i;
  logic [31:0] p0_opcode_i;
  logic [31:0] p0_ra_i;
  logic [31:0] p0_rb_i;
  logic [4:0]  p0_rd_idx_i;
  logic        p0_accept_o;

  logic        p1_valid_i;
  logic [31:0] p1_opcode_i;
  logic [31:0] p1_ra_i;
  logic [31:0] p1_rb_i;
  logic [4:0]  p1_rd_idx_i;
  logic        p1_accept_o;

  logic        div_valid_o;
  logic [31:0] div_opcode_o;
  logic [31:0] div_ra_o;
  logic [31:0] div_rb_o;
  logic        div_wb_valid_i;
  logic [31:0] div_wb_value_i;

  logic        wb_valid_o;
  logic [31:0] wb_value_o;
  logic [4:0]  wb_rd_idx_o;
  logic        wb_pipe_o;
  logic        busy_o;
  logic        timeout_o;

  modport slave (
    input  flush_i,
    input  p0_valid_i, p0_opcode_i, p0_ra_i, p0_rb_i, p0_rd_idx_i,
    output p0_accept_o,
    input  p1_valid_i, p1_opcode_i, p1_ra_i, p1_rb_i, p1_rd_idx_i,
    output p1_accept_o,
    output div_valid_o, div_opcode_o, div_ra_o, div_rb_o,
    input  div_wb_valid_i, div_wb_value_i,
    output wb_valid_o, wb_value_o, wb_rd_idx_o, wb_pipe_o,
    output busy_o, timeout_o
  );

  modport master (
    output flush_i,
    output p0_valid_i, p0_opcode_i, p0_ra_i, p0_rb_i, p0_rd_idx_i,
    input  p0_accept_o,
    output p1_valid_i, p1_opcode_i, p1_ra_i, p1_rb_i, p1_rd_idx_i,
    input  p1_accept_o,
    input  div_valid_o, div_opcode_o, div_ra_o, div_rb_o,
    output div_wb_valid_i, div_wb_value_i,
    input  wb_valid_o, wb_value_o, wb_rd_idx_o, wb_pipe_o,
    input  busy_o, timeout_o
  );
endinterface

// File: rtl/biriscv_div_arbiter.sv
// rtl/biriscv_div_arbiter.sv - round-robin sharing of one divider between two issue pipes
// Tags results with rd/pipe, absorbs flushes of the uncancellable divider, watchdogs hangs.
module biriscv_div_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  biriscv_div_arbiter_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [4:0]       rd_q, rd_d;
  logic             pipe_q, pipe_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             wb_valid_q, wb_valid_d;
  logic [31:0]      wb_value_q, wb_value_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic             wb_pipe_q, wb_pipe_d;

  logic             grant_en;
  logic             grant_pipe;
  logic [31:0]      div_opcode;
  logic [31:0]      div_ra;
  logic [31:0]      div_rb;

  // On a tie the pipe that did not win last time is granted.
  always_comb begin
    grant_en   = (state_q == ST_IDLE) && (bus.p0_valid_i || bus.p1_valid_i) && !bus.flush_i;
    grant_pipe = (bus.p0_valid_i && bus.p1_valid_i) ? !last_grant_q : bus.p1_valid_i;
    div_opcode = 32'd0;
    div_ra     = 32'd0;
    div_rb     = 32'd0;
    if (grant_en) begin
      div_opcode = grant_pipe ? bus.p1_opcode_i : bus.p0_opcode_i;
      div_ra     = grant_pipe ? bus.p1_ra_i     : bus.p0_ra_i;
      div_rb     = grant_pipe ? bus.p1_rb_i     : bus.p0_rb_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rd_d         = rd_q;
    pipe_d       = pipe_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    wb_valid_d   = 1'b0;
    wb_value_d   = wb_value_q;
    wb_rd_d      = wb_rd_q;
    wb_pipe_d    = wb_pipe_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_en) begin
          state_d      = ST_BUSY;
          last_grant_d = grant_pipe;
          pipe_d       = grant_pipe;
          rd_d         = grant_pipe ? bus.p1_rd_idx_i : bus.p0_rd_idx_i;
          cnt_d        = '0;
        end
      end
      ST_BUSY: begin
        if (bus.div_wb_valid_i) begin
          state_d = ST_IDLE;
          if (!bus.flush_i) begin
            wb_valid_d = 1'b1;
            wb_value_d = bus.div_wb_value_i;
            wb_rd_d    = rd_q;
            wb_pipe_d  = pipe_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (bus.flush_i) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // The flushed operation's result still arrives and must be swallowed.
        if (bus.div_wb_valid_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      rd_q         <= 5'd0;
      pipe_q       <= 1'b0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_value_q   <= 32'd0;
      wb_rd_q      <= 5'd0;
      wb_pipe_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rd_q         <= rd_d;
      pipe_q       <= pipe_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      wb_valid_q   <= wb_valid_d;
      wb_value_q   <= wb_value_d;
      wb_rd_q      <= wb_rd_d;
      wb_pipe_q    <= wb_pipe_d;
    end
  end

  assign bus.p0_accept_o  = grant_en && !grant_pipe;
  assign bus.p1_accept_o  = grant_en && grant_pipe;
  assign bus.div_valid_o  = grant_en;
  assign bus.div_opcode_o = div_opcode;
  assign bus.div_ra_o     = div_ra;
  assign bus.div_rb_o     = div_rb;
  assign bus.wb_valid_o   = wb_valid_q;
  assign bus.wb_value_o   = wb_value_q;
  assign bus.wb_rd_idx_o  = wb_rd_q;
  assign bus.wb_pipe_o    = wb_pipe_q;
  assign bus.busy_o       = (state_q != ST_IDLE);
  assign bus.timeout_o    = timeout_q;

endmodule

// File: tb/tb_biriscv_div_arbiter.sv
// tb/tb_biriscv_div_arbiter.sv - directed self-checking bench for biriscv_div_arbiter
module tb_biriscv_div_arbiter;

  localparam logic [31:0] OP_DIV  = 32'h0220_4033;
  localparam logic [31:0] OP_DIVU = 32'h0220_5033;
  localparam logic [31:0] OP_REM  = 32'h0220_6033;
  localparam logic [31:0] OP_REMU = 32'h0220_7033;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic wb_seen;

  biriscv_div_arbiter_if bus();

  biriscv_div_arbiter #(
    .TIMEOUT_CYCLES(64),
    .CNT_W(7)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_p0(input logic v, input logic [31:0] op, input logic [31:0] ra,
                          input logic [31:0] rb, input logic [4:0] rd);
    bus.p0_valid_i  = v;
    bus.p0_opcode_i = op;
    bus.p0_ra_i     = ra;
    bus.p0_rb_i     = rb;
    bus.p0_rd_idx_i = rd;
  endtask

  task automatic drive_p1(input logic v, input logic [31:0] op, input logic [31:0] ra,
                          input logic [31:0] rb, input logic [4:0] rd);
    bus.p1_valid_i  = v;
    bus.p1_opcode_i = op;
    bus.p1_ra_i     = ra;
    bus.p1_rb_i     = rb;
    bus.p1_rd_idx_i = rd;
  endtask

  // Divider stand-in: present one writeback for a single cycle.
  task automatic div_return(input logic [31:0] value);
    bus.div_wb_valid_i = 1'b1;
    bus.div_wb_value_i = value;
    tick();
    bus.div_wb_valid_i = 1'b0;
    bus.div_wb_value_i = 32'd0;
  endtask

  task automatic check_wb(input string tag, input logic [31:0] value, input logic [4:0] rd,
                          input logic pipe);
    check({tag, "_wb_valid"}, 32'(bus.wb_valid_o), 32'd1);
    check({tag, "_wb_value"}, bus.wb_value_o, value);
    check({tag, "_wb_rd"}, 32'(bus.wb_rd_idx_o), 32'(rd));
    check({tag, "_wb_pipe"}, 32'(bus.wb_pipe_o), 32'(pipe));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.flush_i        = 1'b0;
    bus.div_wb_valid_i = 1'b0;
    bus.div_wb_value_i = 32'd0;
    drive_p0(1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    drive_p1(1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    tick();
    tick();
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_timeout", 32'(bus.timeout_o), 32'd0);
    check("rst_wb_valid", 32'(bus.wb_valid_o), 32'd0);
    check("rst_wb_value", bus.wb_value_o, 32'd0);
    check("rst_div_valid", 32'(bus.div_valid_o), 32'd0);
    rst = 1'b0;
    tick();

    // Pipe 0 alone: DIVU 100/7 -> 14
    drive_p0(1'b1, OP_DIVU, 32'd100, 32'd7, 5'd5);
    settle();
    check("t1_p0_accept", 32'(bus.p0_accept_o), 32'd1);
    check("t1_p1_accept", 32'(bus.p1_accept_o), 32'd0);
    check("t1_div_valid", 32'(bus.div_valid_o), 32'd1);
    check("t1_div_op", bus.div_opcode_o, OP_DIVU);
    check("t1_div_ra", bus.div_ra_o, 32'd100);
    check("t1_div_rb", bus.div_rb_o, 32'd7);
    tick();
    drive_p0(1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    drive_p1(1'b1, OP_REMU, 32'd9, 32'd4, 5'd6);
    settle();
    check("t1_busy", 32'(bus.busy_o), 32'd1);
    check("t1_no_accept_busy", 32'(bus.p1_accept_o), 32'd0);
    check("t1_div_valid_busy", 32'(bus.div_valid_o), 32'd0);
    check("t1_div_ra_gated", bus.div_ra_o, 32'd0);
    tick();
    drive_p1(1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    tick();
    bus.div_wb_valid_i = 1'b1;
    bus.div_wb_value_i = 32'd14;
    settle();
    check("t1_wb_not_early", 32'(bus.wb_valid_o), 32'd0);
    tick();
    bus.div_wb_valid_i = 1'b0;
    bus.div_wb_value_i = 32'd0;
    check_wb("t1", 32'd14, 5'd5, 1'b0);
    check("t1_idle", 32'(bus.busy_o), 32'd0);
    tick();
    check("t1_wb_pulse", 32'(bus.wb_valid_o), 32'd0);
    check("t1_wb_hold", bus.wb_value_o, 32'd14);

    // Tie after reset: p0 REM -7%2 first, then p1 DIV 20/-4
    do_reset();
    drive_p0(1'b1, OP_REM, -32'sd7, 32'd2, 5'd3);
    drive_p1(1'b1, OP_DIV, 32'd20, -32'sd4, 5'd9);
    settle();
    check("t2_p0_accept", 32'(bus.p0_accept_o), 32'd1);
    check("t2_p1_accept", 32'(bus.p1_accept_o), 32'd0);
    check("t2_div_ra", bus.div_ra_o, 32'hFFFF_FFF9);
    tick();
    drive_p0(1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    settle();
    check("t2_p1_wait", 32'(bus.p1_accept_o), 32'd0);
    tick();
    div_return(32'hFFFF_FFFF);
    settle();
    check_wb("t2a", 32'hFFFF_FFFF, 5'd3, 1'b0);
    check("t2_p1_accept", 32'(bus.p1_accept_o), 32'd1);
    check("t2_div_op_p1", bus.div_opcode_o, OP_DIV);
    check("t2_div_rb_p1", bus.div_rb_o, 32'hFFFF_FFFC);
    tick();
    drive_p1(1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    tick();
    div_return(32'hFFFF_FFFB);
    check_wb("t2b", 32'hFFFF_FFFB, 5'd9, 1'b1);

    // Round robin: last grant was pipe 1, so pipe 0 wins the next tie
    tick();
    drive_p0(1'b1, OP_DIVU, 32'd50, 32'd5, 5'd1);
    drive_p1(1'b1, OP_DIVU, 32'd60, 32'd6, 5'd2);
    settle();
    check("t3_tie1_p0", 32'(bus.p0_accept_o), 32'd1);
    check("t3_tie1_p1", 32'(bus.p1_accept_o), 32'd0);
    tick();
    drive_p0(1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    tick();
    div_return(32'd10);
    drive_p0(1'b1, OP_DIVU, 32'd70, 32'd7, 5'd1);
    settle();
    check_wb("t3a", 32'd10, 5'd1, 1'b0);
    check("t3_tie2_p1", 32'(bus.p1_accept_o), 32'd1);
    check("t3_tie2_p0", 32'(bus.p0_accept_o), 32'd0);
    check("t3_tie2_ra", bus.div_ra_o, 32'd60);
    tick();
    drive_p1(1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    tick();
    div_return(32'd10);
    settle();
    check_wb("t3b", 32'd10, 5'd2, 1'b1);
    check("t3_p0_next", 32'(bus.p0_accept_o), 32'd1);
    tick();
    drive_p0(1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    tick();
    div_return(32'd10);
    check_wb("t3c", 32'd10, 5'd1, 1'b0);

    // Flush 5 cycles after a grant: DRAIN swallows the result
    tick();
    drive_p0(1'b1, OP_DIV, 32'd81, 32'd9, 5'd12);
    settle();
    check("t4_grant", 32'(bus.p0_accept_o), 32'd1);
    tick();
    drive_p0(1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    repeat (4) tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    drive_p1(1'b1, OP_DIVU, 32'd21, 32'd3, 5'd17);
    settle();
    check("t4_drain_busy", 32'(bus.busy_o), 32'd1);
    check("t4_drain_no_accept", 32'(bus.p1_accept_o), 32'd0);
    tick();
    bus.div_wb_valid_i = 1'b1;
    bus.div_wb_value_i = 32'd9;
    settle();
    check("t4_no_accept_wb", 32'(bus.p1_accept_o), 32'd0);
    tick();
    bus.div_wb_valid_i = 1'b0;
    bus.div_wb_value_i = 32'd0;
    settle();
    check("t4_dropped", 32'(bus.wb_valid_o), 32'd0);
    check("t4_idle", 32'(bus.busy_o), 32'd0);
    check("t4_p1_accept", 32'(bus.p1_accept_o), 32'd1);
    tick();
    drive_p1(1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    tick();
    div_return(32'd7);
    check_wb("t4", 32'd7, 5'd17, 1'b1);

    // Flush and writeback together in BUSY: result dropped, straight to IDLE
    tick();
    drive_p0(1'b1, OP_REMU, 32'd23, 32'd5, 5'd20);
    tick();
    drive_p0(1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    bus.flush_i = 1'b1;
    div_return(32'd3);
    bus.flush_i = 1'b0;
    settle();
    check("t4b_dropped", 32'(bus.wb_valid_o), 32'd0);
    check("t4b_idle", 32'(bus.busy_o), 32'd0);
    check("t4b_wb_hold", bus.wb_value_o, 32'd7);

    // Flush in IDLE blocks the grant for that cycle only
    tick();
    bus.flush_i = 1'b1;
    drive_p0(1'b1, OP_DIVU, 32'd8, 32'd2, 5'd4);
    settle();
    check("t5_flush_no_accept", 32'(bus.p0_accept_o), 32'd0);
    check("t5_flush_no_valid", 32'(bus.div_valid_o), 32'd0);
    tick();
    bus.flush_i = 1'b0;
    settle();
    check("t5_accept", 32'(bus.p0_accept_o), 32'd1);
    tick();
    drive_p0(1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    div_return(32'd4);
    check_wb("t5", 32'd4, 5'd4, 1'b0);

    // Watchdog: divider never answers
    tick();
    drive_p0(1'b1, OP_DIV, 32'd1, 32'd1, 5'd31);
    settle();
    check("t6_grant", 32'(bus.p0_accept_o), 32'd1);
    tick();
    drive_p0(1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    wb_seen = bus.wb_valid_o;
    repeat (63) begin
      tick();
      wb_seen = wb_seen | bus.wb_valid_o;
    end
    check("t6_pre_timeout", 32'(bus.timeout_o), 32'd0);
    check("t6_pre_busy", 32'(bus.busy_o), 32'd1);
    tick();
    check("t6_timeout", 32'(bus.timeout_o), 32'd1);
    check("t6_idle", 32'(bus.busy_o), 32'd0);
    wb_seen = wb_seen | bus.wb_valid_o;
    repeat (3) tick();
    wb_seen = wb_seen | bus.wb_valid_o;
    check("t6_no_wb", 32'(wb_seen), 32'd0);
    check("t6_sticky", 32'(bus.timeout_o), 32'd1);
    do_reset();
    check("t6_rst_clear", 32'(bus.timeout_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/biriscv_div_arbiter.md
Name: biriscv_div_arbiter

Overview:
Shares the single multi-cycle divider between the two issue pipes of the dual-issue core. It accepts DIV/DIVU/REM/REMU requests from pipe 0 and pipe 1 and arbitrates between them round-robin. It issues one operation at a time to the divider and tags the returning result with destination register and pipe. It also absorbs pipeline flushes, because the divider cannot be cancelled, and flags a hung divider through a watchdog.

Parameters:
TIMEOUT_CYCLES, 64, cycles allowed in BUSY/DRAIN before the watchdog fires (must be > 34)
CNT_W, 7, width of the watchdog counter (must hold TIMEOUT_CYCLES)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
flush_i  in  1  pipeline flush; kills the in-flight operation's writeback
p0_valid_i  in  1  pipe 0 divide request, held until accepted
p0_opcode_i  in  32  pipe 0 instruction word
p0_ra_i  in  32  pipe 0 operand A
p0_rb_i  in  32  pipe 0 operand B
p0_rd_idx_i  in  5  pipe 0 destination register
p0_accept_o  out  1  pipe 0 request taken this cycle
p1_valid_i, p1_opcode_i, p1_ra_i, p1_rb_i, p1_rd_idx_i, p1_accept_o  as pipe 0, for pipe 1
div_valid_o  out  1  issue strobe to the divider (opcode_valid_i)
div_opcode_o  out  32  granted opcode
div_ra_o  out  32  granted operand A
div_rb_o  out  32  granted operand B
div_wb_valid_i  in  1  divider writeback_valid_o
div_wb_value_i  in  32  divider writeback_value_o
wb_valid_o  out  1  tagged result valid (1-cycle pulse)
wb_value_o  out  32  result
wb_rd_idx_o  out  5  destination register of the result
wb_pipe_o  out  1  originating pipe (0/1)
busy_o  out  1  state != IDLE
timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset values: all outputs 0; state=IDLE; last_grant_q=1, so pipe 0 wins the first tie; watchdog counter=0.
- States are IDLE, BUSY and DRAIN.
- IDLE, grant rules:
  - A grant is made when (p0_valid_i|p1_valid_i) & !flush_i.
  - Single requester: that pipe is granted.
  - Both requesting: grant pipe !last_grant_q.
- Grant cycle:
  - pX_accept_o=1 and div_valid_o=1, combinational in the same cycle.
  - div_opcode_o/ra/rb are muxed from the granted pipe.
  - rd_idx and pipe id are latched; last_grant_q is updated; state goes to BUSY.
  - When div_valid_o=0, div_* data outputs are 0.
- Accept/valid and flush rules:
  - Never more than one accept per cycle.
  - No accept outside IDLE.
  - flush_i in IDLE suppresses the grant that cycle.
- BUSY:
  - div_wb_valid_i=1 & !flush_i: next cycle wb_valid_o=1 with wb_value_o=div_wb_value_i and the latched rd/pipe; state goes to IDLE.
  - flush_i=1 without div_wb_valid_i: go to DRAIN.
  - flush_i and div_wb_valid_i in the same cycle: result dropped, no wb_valid_o, go to IDLE.
- DRAIN: the next div_wb_valid_i is discarded (no wb_valid_o), then go to IDLE. flush_i has no further effect.
- Re-grant timing: the earliest re-grant is the cycle after the state returns to IDLE. With the divider's 2-cycle repeat-operand fast path, back-to-back issues are spaced 3 cycles apart.
- div_wb_valid_i in IDLE is ignored.
- Watchdog:
  - The counter is cleared on entry to BUSY and increments each cycle in BUSY/DRAIN.
  - When the count reaches TIMEOUT_CYCLES-1 with no div_wb_valid_i: timeout_o is set (sticky until reset), state goes to IDLE, and no wb_valid_o is produced.
- wb_* data outputs hold their last value when wb_valid_o=0.
- Reset asserted mid-operation returns everything to reset values immediately; the arbiter does not track the divider's result from a pre-reset issue.

Test Plan:
- Pipe 0 alone, DIVU ra=100 rb=7 rd=5 → p0_accept_o pulses 1 cycle with div_valid_o. In BUSY until the divider returns. wb_valid_o=1 with value=14, rd=5, pipe=0, exactly 1 cycle after div_wb_valid_i.
- Both pipes valid in the same cycle after reset (p0 REM -7,2 rd=3; p1 DIV 20,-4 rd=9) → p0 granted first, result -1 rd=3 pipe=0. Then p1 is granted the cycle after IDLE, result -5 rd=9 pipe=1.
- Round-robin check: after a pipe 1 grant, both pipes request again → pipe 0 granted. Then after a pipe 0 grant with both requesting → pipe 1 granted.
- flush_i pulsed 5 cycles after a grant → state DRAIN. The divider writeback is consumed with wb_valid_o staying 0. A new p1 request is accepted the cycle after return to IDLE.
- flush_i asserted together with p0_valid_i in IDLE → no accept that cycle. Accept occurs the first cycle flush_i=0.
- Divider output tied off (div_wb_valid_i=0), grant issued → timeout_o rises after 64 cycles in BUSY and stays 1, state returns to IDLE, no wb_valid_o. rst_i pulse clears timeout_o.
